// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-port data memory.
// Extracts and extends loads, read-modify-writes sub-word stores, and rejects illegal requests.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, RESP} state_e;

    localparam logic [1:0]  SZ_B       = 2'b00;
    localparam logic [1:0]  SZ_H       = 2'b01;
    localparam logic [1:0]  SZ_W       = 2'b10;
    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

    state_e      state_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_wdata_q;
    logic        req_err_c;

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sext);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        case (size)
            SZ_B:    res = sext ? {{24{byte_sh[7]}}, byte_sh[7:0]} : {24'h0, byte_sh[7:0]};
            SZ_H:    res = sext ? {{16{half_sh[15]}}, half_sh[15:0]} : {16'h0, half_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte/half lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == SZ_B) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wdata} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    always_comb begin
        req_err_c = 1'b0;
        if (req_size == 2'b11)                             req_err_c = 1'b1;
        if (req_size == SZ_H && req_addr[0])               req_err_c = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00)    req_err_c = 1'b1;
        if ({2'b00, req_addr} >= ADDR_LIMIT)               req_err_c = 1'b1;
    end

    // Single FSM register block; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= 32'h0;
        end else begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lane_q      <= req_addr[1:0];
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (req_err_c) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (!req_store) begin
                            state_q    <= LD;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                        end else if (req_size == SZ_W) begin
                            state_q     <= ST_WR;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                        end else begin
                            state_q    <= ST_RD;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                LD: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_extract(mem_rdata, lane_q, size_q, signed_q);
                    mem_addr_q   <= 32'h0;
                end
                ST_RD: begin
                    state_q     <= ST_WR;
                    mem_write_q <= 1'b1;
                    mem_wdata_q <= store_merge(mem_rdata, lane_q, size_q, wdata_q);
                end
                ST_WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    mem_addr_q   <= 32'h0;
                    mem_wdata_q  <= 32'h0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory and hand-computed expectations.
module tb_mem_access_unit;

    localparam int unsigned MEM_WORDS = 4096;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic        mem_init_done = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          resp_n   = 0;
    int          both_hi  = 0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] resp_log [0:63];

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[13:2]];

    // Memory model: one-time preload during the first reset, then synchronous writes.
    always @(posedge clk) begin
        if (!rst_n && !mem_init_done) begin
            mem[4]        <= 32'h8899_AABB;
            mem[8]        <= 32'h1122_3344;
            mem[16]       <= 32'hA5A5_A5A5;
            mem[MEM_WORDS-1] <= 32'hCAFE_F00D;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[13:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_data <= mem_wdata;
            last_wr_addr <= mem_addr;
        end
        if (mem_read && mem_write) both_hi <= both_hi + 1;
        if (resp_valid) begin
            resp_log[resp_n % 64] <= resp_rdata;
            resp_n <= resp_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and check latency, response and memory traffic.
    task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr);
        int rd0, wr0, k;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_lat"},   32'(k), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"},   32'(resp_err), 32'(exp_err));
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd0, wr0, rs0, base, guard;
        logic [31:0] b2b_addr [0:2];
        logic [1:0]  b2b_size [0:2];
        logic        b2b_sgn  [0:2];
        logic [31:0] b2b_exp  [0:2];

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        #12;
        check("rst_ready",  32'(req_ready),  32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_err",    32'(resp_err),   32'd0);
        check("rst_rdata",  resp_rdata,      32'h0);
        check("rst_mread",  32'(mem_read),   32'd0);
        check("rst_mwrite", 32'(mem_write),  32'd0);
        check("rst_maddr",  mem_addr,        32'h0);
        check("rst_mwdata", mem_wdata,       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req("ldb_s_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 1, 0);
        do_req("ldh_u_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'h0000_8899, 1'b0, 1, 0);
        do_req("ldw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8899_AABB, 1'b0, 1, 0);
        do_req("stb_13",    1'b1, 2'b00, 1'b0, 32'h13, 32'h5C, 3, 32'h0, 1'b0, 1, 1);
        check("stb_13_wdata", last_wr_data, 32'h5C99_AABB);
        check("stb_13_waddr", last_wr_addr, 32'h10);
        do_req("ldw_10_after", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 2, 32'h5C99_AABB, 1'b0, 1, 0);
        do_req("sth_mis_21", 1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF, 1, 32'h0, 1'b1, 0, 0);
        do_req("ldw_mis_22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("ldb_oor",    1'b0, 2'b00, 1'b0, 32'h4000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("ld_sz11",    1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        do_req("ldw_last",   1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1, 0);
        do_req("stw_20",     1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
        check("stw_20_wdata", last_wr_data, 32'hDEAD_BEEF);
        do_req("ldh_s_22",   1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 2, 32'hFFFF_DEAD, 1'b0, 1, 0);
        do_req("sth_22",     1'b1, 2'b01, 1'b0, 32'h22, 32'hAB12_1234, 3, 32'h0, 1'b0, 1, 1);
        check("sth_22_wdata", last_wr_data, 32'h1234_BEEF);
        do_req("ldb_u_23",   1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 2, 32'h0000_0012, 1'b0, 1, 0);

        // Reset asserted while a byte store sits in its read phase.
        wr0 = wr_cnt;
        rs0 = resp_n;
        req_store  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h41;
        req_wdata  = 32'h77;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstmid_in_strd", 32'(mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ready",  32'(req_ready),  32'd1);
        check("rstmid_mread",  32'(mem_read),   32'd0);
        check("rstmid_mwrite", 32'(mem_write),  32'd0);
        check("rstmid_maddr",  mem_addr,        32'h0);
        check("rstmid_rvalid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_nowrite", 32'(wr_cnt - wr0), 32'd0);
        check("rstmid_noresp",  32'(resp_n - rs0), 32'd0);
        check("rstmid_mem",     mem[16], 32'hA5A5_A5A5);
        do_req("ldb_u_41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 2, 32'h0000_00A5, 1'b0, 1, 0);

        // Three loads with req_valid held high; fields advance only on acceptance.
        b2b_addr[0] = 32'h10; b2b_size[0] = 2'b10; b2b_sgn[0] = 1'b0; b2b_exp[0] = 32'h5C99_AABB;
        b2b_addr[1] = 32'h12; b2b_size[1] = 2'b00; b2b_sgn[1] = 1'b0; b2b_exp[1] = 32'h0000_0099;
        b2b_addr[2] = 32'h10; b2b_size[2] = 2'b01; b2b_sgn[2] = 1'b1; b2b_exp[2] = 32'hFFFF_AABB;
        rd0  = rd_cnt;
        base = resp_n;
        req_store = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr   = b2b_addr[i];
            req_size   = b2b_size[i];
            req_signed = b2b_sgn[i];
            guard = 0;
            while (!req_ready && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("b2b_accept_bound", 32'(guard < 20), 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_resp_count", 32'(resp_n - base), 32'd3);
        check("b2b_read_count", 32'(rd_cnt - rd0),  32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_rdata%0d", i), resp_log[(base + i) % 64], b2b_exp[i]);

        check("rd_wr_exclusive", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
